// File: rtl/sram_responder.sv
// Byte-wide SRAM responder: stores controller writes with a parity bit and
// valid flag, returns reads two cycles after output-enable is sampled.
module sram_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_we_n,
  input  logic              sram_oe_n,
  input  logic [7:0]        sram_din,
  input  logic              inj_par_err,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_en,
  output logic              busy,
  output logic              par_err,
  output logic              uninit_rd,
  output logic              prot_hit,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [1:0]        dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PROT_ADDR = '1;

  typedef enum logic [1:0] {IDLE, WR_DONE, RD_FETCH, RD_DRIVE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem   [DEPTH];
  logic              par_mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              par_q;
  logic              vld_q;
  logic              prot_q;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       rd_cnt_q;

  logic wr_start, wr_accept, wr_reject, rd_start, rd_exit;

  // Write wins over read when both strobes are low in IDLE.
  assign wr_start  = (state_q == IDLE) && !cs_n && !sram_we_n;
  assign wr_accept = wr_start && (sram_addr != PROT_ADDR);
  assign wr_reject = wr_start && (sram_addr == PROT_ADDR);
  assign rd_start  = (state_q == IDLE) && !cs_n && sram_we_n && !sram_oe_n;
  assign rd_exit   = (state_q == RD_DRIVE) && (sram_oe_n || cs_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_accept)     state_d = WR_DONE;
        else if (rd_start) state_d = RD_FETCH;
      end
      WR_DONE:  state_d = IDLE;
      RD_FETCH: state_d = RD_DRIVE;
      RD_DRIVE: if (rd_exit) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_dout_en = (state_q == RD_DRIVE);
    busy         = (state_q != IDLE);
    sram_dout    = 8'h00;
    par_err      = 1'b0;
    uninit_rd    = 1'b0;
    if (state_q == RD_DRIVE) begin
      sram_dout = vld_q ? data_q : 8'h00;
      par_err   = vld_q && ((^data_q) != par_q);
      uninit_rd = !vld_q;
    end
  end

  assign prot_hit    = prot_q;
  assign wr_cnt      = wr_cnt_q;
  assign rd_cnt      = rd_cnt_q;
  assign dbg_state_o = state_q;

  // Storage array and its parity carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[sram_addr]     <= sram_din;
      par_mem[sram_addr] <= (^sram_din) ^ inj_par_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= 8'h00;
      par_q    <= 1'b0;
      vld_q    <= 1'b0;
      prot_q   <= 1'b0;
      wr_cnt_q <= 16'h0000;
      rd_cnt_q <= 16'h0000;
    end else begin
      prot_q <= wr_reject;
      if (wr_accept) begin
        valid_q[sram_addr] <= 1'b1;
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (rd_start) addr_q <= sram_addr;
      if (state_q == RD_FETCH) begin
        data_q <= mem[addr_q];
        par_q  <= par_mem[addr_q];
        vld_q  <= valid_q[addr_q];
      end
      if (rd_exit && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

endmodule
